fir_mac_scheduler: RTL

Time-multiplexed FIR controller. It replaces the fully parallel 128-multiplier filter with a single shared multiply-accumulate unit. Each accepted ADC sample is written into a circular sample buffer, then the block sequences TAPS multiply-accumulate cycles against a run-time loadable coefficient memory. The scaled, saturated result goes to the DAC/display path with a one-cycle valid strobe. The block sits between the ADC sampling logic and the DAC output register.

---
 rtl/fir_mac_scheduler.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: time-multiplexed FIR filter controller.
// One shared multiply-accumulate unit walks all TAPS coefficients for every
// accepted ADC sample. Samples live in a circular buffer. Coefficients are
// loadable at run time while idle. The shifted, clamped result is presented
// with a one-cycle valid strobe.
//
// Cycle plan, counting the cycle in which sample_valid is accepted as cycle 1:
//   cycle 1            : write sample, latch base pointer (IDLE)
//   cycles 2..TAPS+1   : issue one tap per cycle, product registered (MAC)
//   cycle TAPS+2       : fold in the last product, register the outputs (DRAIN)
//   cycle TAPS+3       : result_valid high, block still busy (OUT)
// The next sample can therefore be accepted TAPS+3 cycles after the previous one.
module fir_mac_scheduler #(
    parameter int TAPS  = 128,
    parameter int AW    = 7,
    parameter int DW    = 8,
    parameter int CW    = 16,
    parameter int ACCW  = 32,
    parameter int SHIFT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_valid,
    input  logic [DW-1:0]   adc_in,
    input  logic            coef_we,
    input  logic [AW-1:0]   coef_addr,
    input  logic [CW-1:0]   coef_data,
    input  logic            clr_flags,
    output logic            busy,
    output logic            result_valid,
    output logic [7:0]      dac_out,
    output logic [ACCW-1:0] result_raw,
    output logic            overrun,
    output logic            coef_err
);

    // Product width: signed coefficient times zero-extended (DW+1 bit) sample.
    localparam int PW = CW + DW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [AW-1:0] K_LAST   = AW'(TAPS - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   FILL_MAX = (AW + 1)'(TAPS);
    localparam logic [AW:0]   FILL_ONE = (AW + 1)'(1);

    logic [DW-1:0]          sample_mem [TAPS];
    logic signed [CW-1:0]   coef_mem   [TAPS];

    logic [1:0]             state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          base_q, base_d;
    logic [AW-1:0]          k_q, k_d;
    logic [AW:0]            fill_q, fill_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [PW-1:0]   prod_q, prod_d;
    logic                   prod_vld_q, prod_vld_d;
    logic                   result_valid_q, result_valid_d;
    logic signed [ACCW-1:0] result_raw_q, result_raw_d;
    logic [7:0]             dac_out_q, dac_out_d;
    logic                   overrun_q, overrun_d;
    logic                   coef_err_q, coef_err_d;

    logic                   busy_w;
    logic                   accept;
    logic                   coef_wr;
    logic [AW-1:0]          rd_addr;
    logic [DW-1:0]          tap_x;
    logic signed [CW-1:0]   tap_c;
    logic                   tap_en;
    logic signed [PW-1:0]   c_ext;
    logic signed [PW-1:0]   x_ext;
    logic signed [PW-1:0]   prod_now;
    logic signed [ACCW-1:0] sum_now;

    // Arithmetic shift, then clamp to the unsigned 8-bit DAC range.
    function automatic logic [7:0] sat_dac(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] s;
        s = v >>> SHIFT;
        if (s[ACCW-1])
            sat_dac = 8'd0;
        else if (|s[ACCW-2:8])
            sat_dac = 8'd255;
        else
            sat_dac = s[7:0];
    endfunction

    // Tap fetch, product and running sum for the current tap index.
    always_comb begin
        busy_w   = (state_q != ST_IDLE);
        accept   = sample_valid && !busy_w;
        coef_wr  = coef_we && !busy_w;
        rd_addr  = base_q - k_q;
        tap_x    = sample_mem[rd_addr];
        tap_c    = coef_mem[k_q];
        // Taps reaching past the number of samples seen since reset read stale RAM.
        tap_en   = ({1'b0, k_q} < fill_q);
        c_ext    = {{(PW - CW){tap_c[CW-1]}}, tap_c};
        x_ext    = {{(PW - DW){1'b0}}, tap_x};
        prod_now = c_ext * x_ext;
        sum_now  = acc_q + {{(ACCW - PW){prod_q[PW-1]}}, prod_q};
    end

    // Sequencer: next-state, pointer, accumulator, output and flag logic.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        base_d         = base_q;
        k_d            = k_q;
        fill_d         = fill_q;
        acc_d          = acc_q;
        prod_d         = prod_q;
        prod_vld_d     = prod_vld_q;
        result_valid_d = 1'b0;
        result_raw_d   = result_raw_q;
        dac_out_d      = dac_out_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    base_d     = wr_ptr_q;
                    wr_ptr_d   = wr_ptr_q + PTR_ONE;
                    fill_d     = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_ONE;
                    acc_d      = '0;
                    k_d        = '0;
                    prod_vld_d = 1'b0;
                    state_d    = ST_MAC;
                end
            end
            ST_MAC: begin
                prod_d     = tap_en ? prod_now : '0;
                prod_vld_d = 1'b1;
                if (prod_vld_q)
                    acc_d = sum_now;
                if (k_q == K_LAST)
                    state_d = ST_DRAIN;
                else
                    k_d = k_q + PTR_ONE;
            end
            ST_DRAIN: begin
                // Last product folds in here; outputs are captured on the same
                // edge so they are valid throughout the OUT cycle.
                acc_d          = sum_now;
                prod_vld_d     = 1'b0;
                result_raw_d   = sum_now;
                dac_out_d      = sat_dac(sum_now);
                result_valid_d = 1'b1;
                state_d        = ST_OUT;
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Sticky flags: a set event in the same cycle as clr_flags wins.
        overrun_d  = (overrun_q  && !clr_flags) || (sample_valid && busy_w);
        coef_err_d = (coef_err_q && !clr_flags) || (coef_we && busy_w);
    end

    // Control and output registers, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            base_q         <= '0;
            k_q            <= '0;
            fill_q         <= '0;
            acc_q          <= '0;
            prod_vld_q     <= 1'b0;
            result_valid_q <= 1'b0;
            result_raw_q   <= '0;
            dac_out_q      <= '0;
            overrun_q      <= 1'b0;
            coef_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            base_q         <= base_d;
            k_q            <= k_d;
            fill_q         <= fill_d;
            acc_q          <= acc_d;
            prod_vld_q     <= prod_vld_d;
            result_valid_q <= result_valid_d;
            result_raw_q   <= result_raw_d;
            dac_out_q      <= dac_out_d;
            overrun_q      <= overrun_d;
            coef_err_q     <= coef_err_d;
        end
    end

    // Product pipeline register; only consumed when prod_vld_q says so.
    always_ff @(posedge clk) begin
        prod_q <= prod_d;
    end

    // Circular sample buffer write on acceptance.
    always_ff @(posedge clk) begin
        if (accept)
            sample_mem[wr_ptr_q] <= adc_in;
    end

    // Coefficient memory write, only while idle so a pass never sees a mix.
    always_ff @(posedge clk) begin
        if (coef_wr)
            coef_mem[coef_addr] <= coef_data;
    end

    assign busy         = busy_w;
    assign result_valid = result_valid_q;
    assign result_raw   = result_raw_q;
    assign dac_out      = dac_out_q;
    assign overrun      = overrun_q;
    assign coef_err     = coef_err_q;

endmodule
